// File: rtl/ss_map_sequencer.sv
// Map bank sequencer: turns LocX edge crossings and explicit requests into frame-aligned,
// blanked map switches, and tells the position logic where the player re-enters.
module ss_map_sequencer #(
    parameter int         NUM_MAPS     = 3,
    parameter logic [7:0] EDGE_RIGHT   = 8'h7C,
    parameter logic [7:0] EDGE_LEFT    = 8'h00,
    parameter logic [7:0] ENTRY_RIGHT  = 8'h01,
    parameter logic [7:0] ENTRY_LEFT   = 8'h7B,
    parameter int         BLANK_FRAMES = 2
) (
    input  logic       clk_75,
    input  logic       reset,
    input  logic       frame_start,
    input  logic [7:0] LocX,
    input  logic       req_valid,
    input  logic [3:0] req_map,
    output logic       req_ready,
    output logic [3:0] map_sel,
    output logic       blank_video,
    output logic       locx_load,
    output logic [7:0] locx_load_val,
    output logic       swap_done,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FRAME,
        BLANK
    } state_t;

    localparam logic [3:0] LAST_MAP  = 4'(NUM_MAPS - 1);
    localparam logic [3:0] BLANK_CNT = 4'(BLANK_FRAMES);

    state_t     state, state_nxt;
    logic [3:0] target, target_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [3:0] map_sel_nxt;
    logic [7:0] entry, entry_nxt;
    logic [7:0] prev_locx;
    logic [7:0] locx_load_val_nxt;
    logic       blank_nxt, load_nxt, done_nxt, busy_nxt;

    logic       rtrig, ltrig;
    logic [3:0] req_clamped, next_map, prev_map;

    // Triggers fire only on a transition into the edge value, so a player parked on
    // the edge (including across a switch) never retriggers.
    assign rtrig = (LocX == EDGE_RIGHT) && (prev_locx != EDGE_RIGHT);
    assign ltrig = (LocX == EDGE_LEFT) && (prev_locx != EDGE_LEFT) && (map_sel != 4'd0);

    assign req_clamped = (req_map > LAST_MAP) ? LAST_MAP : req_map;
    assign next_map    = (map_sel == LAST_MAP) ? 4'd0 : map_sel + 4'd1;
    assign prev_map    = map_sel - 4'd1;

    // NOTE: every variable gets a default first, so no path through the case leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_nxt         = state;
        target_nxt        = target;
        entry_nxt         = entry;
        cnt_nxt           = cnt;
        map_sel_nxt       = map_sel;
        locx_load_val_nxt = locx_load_val;
        blank_nxt         = blank_video;
        busy_nxt          = busy;
        load_nxt          = 1'b0;
        done_nxt          = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    target_nxt = req_clamped;
                    entry_nxt  = ENTRY_RIGHT;
                    if (req_clamped == map_sel) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = WAIT_FRAME;
                        busy_nxt  = 1'b1;
                    end
                end else if (rtrig) begin
                    target_nxt = next_map;
                    entry_nxt  = ENTRY_RIGHT;
                    state_nxt  = WAIT_FRAME;
                    busy_nxt   = 1'b1;
                end else if (ltrig) begin
                    target_nxt = prev_map;
                    entry_nxt  = ENTRY_LEFT;
                    state_nxt  = WAIT_FRAME;
                    busy_nxt   = 1'b1;
                end
            end

            WAIT_FRAME: begin
                if (frame_start) begin
                    map_sel_nxt       = target;
                    blank_nxt         = 1'b1;
                    load_nxt          = 1'b1;
                    locx_load_val_nxt = entry;
                    cnt_nxt           = BLANK_CNT;
                    state_nxt         = BLANK;
                end
            end

            BLANK: begin
                // The switching frame_start loads the count, so ending on cnt==1 gives
                // exactly BLANK_FRAMES blanked frame periods.
                if (frame_start) begin
                    cnt_nxt = cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        blank_nxt = 1'b0;
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
                blank_nxt = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_75 or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            target        <= 4'd0;
            entry         <= 8'h00;
            cnt           <= 4'd0;
            map_sel       <= 4'd0;
            locx_load_val <= 8'h00;
            blank_video   <= 1'b0;
            locx_load     <= 1'b0;
            swap_done     <= 1'b0;
            busy          <= 1'b0;
            req_ready     <= 1'b1;
            prev_locx     <= EDGE_LEFT;
        end else begin
            state         <= state_nxt;
            target        <= target_nxt;
            entry         <= entry_nxt;
            cnt           <= cnt_nxt;
            map_sel       <= map_sel_nxt;
            locx_load_val <= locx_load_val_nxt;
            blank_video   <= blank_nxt;
            locx_load     <= load_nxt;
            swap_done     <= done_nxt;
            busy          <= busy_nxt;
            req_ready     <= (state_nxt == IDLE);
            prev_locx     <= LocX;
        end
    end

endmodule
